pp_accumulator: RTL and testbench

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

---
 rtl/npu_pkg.sv | 26 ++
 rtl/pp_reduce.sv | 43 ++++
 rtl/pp_accumulator.sv | 156 +++++++++++++++
 tb/tb_pp_accumulator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared Booth partial-product geometry and correction constant, used by the
// partial-product generator and by pp_accumulator / pp_reduce.
package npu_pkg;

  localparam int unsigned Pp0W  = 11;
  localparam int unsigned PpW   = 9;
  localparam int unsigned ProdW = 16;

  localparam int unsigned Row1Shift = 2;
  localparam int unsigned Row2Shift = 4;
  localparam int unsigned Row3Shift = 6;

  // Cancels the sign-extension-prevention offsets the PPG folds into each row.
  localparam logic [ProdW-1:0] BoothCorr = 16'hA800;

  typedef enum logic {
    StAccum,
    StHold
  } ppa_state_e;

  function automatic logic [ProdW-1:0] place_row(input logic [PpW-1:0] row,
                                                 input int unsigned  shift);
    return ProdW'(row) << shift;
  endfunction

endpackage

// File: rtl/pp_reduce.sv
// Combinational reduction of four Booth rows, their increment bits and the
// correction constant into a 16-bit two's-complement product.
module pp_reduce
  import npu_pkg::*;
(
  input  logic [Pp0W-1:0]  pp0_i,
  input  logic [PpW-1:0]   pp1_i,
  input  logic [PpW-1:0]   pp2_i,
  input  logic [PpW-1:0]   pp3_i,
  input  logic             neg0_i,
  input  logic             neg1_i,
  input  logic             neg2_i,
  input  logic             neg3_i,
  output logic [ProdW-1:0] prod_o
);

  logic [ProdW-1:0] r0, r1, r2, r3, r4;
  logic [ProdW-1:0] s1, c1, s2, c2, s3, c3;

  always_comb begin
    r0 = ProdW'(pp0_i);
    r1 = place_row(pp1_i, Row1Shift);
    r2 = place_row(pp2_i, Row2Shift);
    r3 = place_row(pp3_i, Row3Shift);
    // Increment bits land on zero bit positions of the correction constant.
    r4            = BoothCorr;
    r4[0]         = neg0_i;
    r4[Row1Shift] = neg1_i;
    r4[Row2Shift] = neg2_i;
    r4[Row3Shift] = neg3_i;

    // 4:2 compressor over the rows, then one more 3:2 for the constant row.
    s1 = r0 ^ r1 ^ r2;
    c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    s2 = s1 ^ c1 ^ r3;
    c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
    s3 = s2 ^ c2 ^ r4;
    c3 = ((s2 & c2) | (s2 & r4) | (c2 & r4)) << 1;

    prod_o = s3 + c3;
  end

endmodule

// File: rtl/pp_accumulator.sv
// Sums TERMS Booth products per window into a signed ACC_W-bit result with a
// valid/ready output. Define PPA_SAT_EN for saturating accumulation + out_sat.
module pp_accumulator
  import npu_pkg::*;
#(
  parameter int unsigned TERMS = 9,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Pp0W-1:0]  pp0,
  input  logic [PpW-1:0]   pp1,
  input  logic [PpW-1:0]   pp2,
  input  logic [PpW-1:0]   pp3,
  input  logic             neg0,
  input  logic             neg1,
  input  logic             neg2,
  input  logic             neg3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam int unsigned    CntW    = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TERMS - 1);

  logic [ProdW-1:0] prod;
  logic [ProdW-1:0] p_data_q, p_data_d;
  logic             p_valid_q, p_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  ppa_state_e       state_q;
  logic [ACC_W-1:0] out_data_q;
  logic             p_last, p_stall, p_adv, load;
  logic [ACC_W-1:0] prod_ext, sum;

  pp_reduce u_reduce (
    .pp0_i  (pp0),
    .pp1_i  (pp1),
    .pp2_i  (pp2),
    .pp3_i  (pp3),
    .neg0_i (neg0),
    .neg1_i (neg1),
    .neg2_i (neg2),
    .neg3_i (neg3),
    .prod_o (prod)
  );

  assign out_valid = (state_q == StHold);
  assign p_last    = p_valid_q && (cnt_q == LastCnt);
  // Only the closing term can block: it needs the output register free.
  assign p_stall   = p_last && out_valid && !out_ready;
  assign p_adv     = p_valid_q && !p_stall;
  assign in_ready  = !p_valid_q || p_adv;
  assign load      = p_adv && p_last;
  assign prod_ext  = ACC_W'($signed(p_data_q));
  assign out_data  = out_data_q;

`ifdef PPA_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           ovf;
  logic           win_sat_q, out_sat_q;

  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign out_sat  = out_sat_q;

  always_comb begin
    sum = sum_wide[ACC_W-1:0];
    if (ovf) begin
      sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_sat_q <= 1'b0;
      out_sat_q <= 1'b0;
    end else if (p_adv) begin
      if (p_last) begin
        win_sat_q <= 1'b0;
        out_sat_q <= win_sat_q | ovf;
      end else begin
        win_sat_q <= win_sat_q | ovf;
      end
    end
  end
`else
  assign sum     = acc_q + prod_ext;
  assign out_sat = 1'b0;
`endif

  always_comb begin
    p_valid_d = p_valid_q;
    p_data_d  = p_data_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (p_adv) begin
      p_valid_d = 1'b0;
      if (p_last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
    if (in_valid && in_ready) begin
      p_valid_d = 1'b1;
      p_data_d  = prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  // A fresh result may replace the held one in the same edge it is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StAccum;
      out_data_q <= '0;
    end else begin
      case (state_q)
        StAccum: begin
          if (load) begin
            out_data_q <= sum;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (load) begin
            out_data_q <= sum;
          end else if (out_ready) begin
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator: Booth operands are encoded here, and
// expected sums are hand-computed constants or the plain integer product.
module tb_pp_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [10:0] pp0;
  logic [8:0]  pp1, pp2, pp3;
  logic        neg0, neg1, neg2, neg3;

  logic        in_ready, out_valid, out_sat;
  logic [19:0] out_data;
  logic        in_ready1, out_valid1, out_sat1;
  logic [19:0] out_data1;
  logic        in_ready16, out_valid16, out_sat16;
  logic [15:0] out_data16;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [19:0] results[$];
  logic [19:0] xq[$];
  logic [19:0] exp_x;
  logic        prev_v, prev_r, saw_stall;
  int          ctl_n, got_x, cyc_x;

  always #5 clk = ~clk;

  pp_accumulator #(.TERMS(9), .ACC_W(20)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(neg0), .neg1(neg1), .neg2(neg2), .neg3(neg3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  pp_accumulator #(.TERMS(1), .ACC_W(20)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(neg0), .neg1(neg1), .neg2(neg2), .neg3(neg3),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1)
  );

  pp_accumulator #(.TERMS(9), .ACC_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(neg0), .neg1(neg1), .neg2(neg2), .neg3(neg3),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_sat(out_sat16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Radix-4 Booth rows with sign-extension prevention (offset removed by 0xA800).
  task automatic set_operands(input logic signed [7:0] a, input logic signed [7:0] b);
    logic [8:0] bx, m, row;
    logic [2:0] trip;
    logic       s;
    bx = {b, 1'b0};
    for (int i = 0; i < 4; i++) begin
      trip = bx[2*i +: 3];
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: m = {a[7], a};
        3'b011, 3'b100:                 m = {a, 1'b0};
        default:                        m = '0;
      endcase
      row = trip[2] ? ~m : m;
      s   = row[8];
      case (i)
        0: begin pp0 = {~s, s, s, row[7:0]}; neg0 = trip[2]; end
        1: begin pp1 = {~s, row[7:0]};       neg1 = trip[2]; end
        2: begin pp2 = {~s, row[7:0]};       neg2 = trip[2]; end
        default: begin pp3 = {~s, row[7:0]}; neg3 = trip[2]; end
      endcase
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_sat", 32'(out_sat), 0);
    check_eq("rst_in_ready1", 32'(in_ready1), 1);
    check_eq("rst_in_ready16", 32'(in_ready16), 1);
    check_eq("rst_out_valid1", 32'(out_valid1), 0);
    check_eq("rst_out_sat1", 32'(out_sat1), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Entered and left on a falling edge; the transfer happens in between.
  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b);
    int n;
    set_operands(a, b);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_window(input logic signed [7:0] a, input logic signed [7:0] b,
                             input int n);
    for (int k = 0; k < n; k++) begin
      send(a, b);
      check_eq("quiet", 32'(out_valid), 0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    set_operands(8'sd0, 8'sd0);
    do_reset();

    // 3x5 nine times: 135, one cycle of out_valid, two cycles after last transfer.
    send_window(8'sd3, 8'sd5, 9);
    @(negedge clk);
    check_eq("w135_valid", 32'(out_valid), 1);
    check_eq("w135_data", 32'(out_data), 135);
    @(negedge clk);
    check_eq("w135_drop", 32'(out_valid), 0);

    // (-128)^2 nine times: wide, narrow, and saturating/wrapping narrow.
    send_window(-8'sd128, -8'sd128, 9);
    @(negedge clk);
    check_eq("big_valid", 32'(out_valid), 1);
    check_eq("big_data", 32'(out_data), 147456);
    check_eq("big_sat", 32'(out_sat), 0);
    check_eq("n16_valid", 32'(out_valid16), 1);
`ifdef PPA_SAT_EN
    check_eq("n16_data", 32'(out_data16), 32767);
    check_eq("n16_sat", 32'(out_sat16), 1);
`else
    check_eq("n16_data", 32'(out_data16), 16384);
    check_eq("n16_sat", 32'(out_sat16), 0);
`endif

    // Backpressure across two windows.
    do_reset();
    prev_v    = 1'b0;
    prev_r    = 1'b1;
    saw_stall = 1'b0;
    fork
      for (int k = 0; k < 18; k++) send(8'sd3, 8'sd5);
      begin
        ctl_n = 0;
        while (!out_valid && ctl_n < 40) begin
          @(negedge clk);
          ctl_n++;
        end
        out_ready = 1'b0;
        repeat (12) @(negedge clk);
        out_ready = 1'b1;
      end
      repeat (60) begin
        @(negedge clk);
        #1;
        if (prev_v && !prev_r) begin
          check_eq("hold_valid", 32'(out_valid), 1);
          check_eq("hold_data", 32'(out_data), 135);
        end
        if (!in_ready && out_valid && !out_ready) saw_stall = 1'b1;
        if (out_valid && out_ready) results.push_back(out_data);
        prev_v = out_valid;
        prev_r = out_ready;
      end
    join
    check_eq("bp_stall_seen", 32'(saw_stall), 1);
    check_eq("bp_count", 32'(results.size()), 2);
    if (results.size() == 2) begin
      check_eq("bp_first", 32'(results[0]), 135);
      check_eq("bp_second", 32'(results[1]), 135);
    end

    // Abort a window mid-way, then a clean 2x2 window.
    do_reset();
    send_window(8'sd3, 8'sd5, 4);
    do_reset();
    send_window(8'sd2, 8'sd2, 9);
    @(negedge clk);
    check_eq("abort_valid", 32'(out_valid), 1);
    check_eq("abort_data", 32'(out_data), 36);

    // TERMS=1 pass-through over every operand pair.
    do_reset();
    got_x = 0;
    cyc_x = 0;
    fork
      for (int a = -128; a < 128; a++) begin
        for (int b = -128; b < 128; b++) begin
          send(8'(a), 8'(b));
          xq.push_back(20'(a * b));
        end
      end
      while (got_x < 65536 && cyc_x < 70000) begin
        @(negedge clk);
        #1;
        cyc_x++;
        if (out_valid1) begin
          if (xq.size() > 0) begin
            exp_x = xq.pop_front();
            check_eq("x_prod", 32'(out_data1), 32'(exp_x));
            got_x++;
          end else begin
            check_eq("x_extra", 32'(xq.size()), 1);
          end
        end
      end
    join
    check_eq("x_count", 32'(got_x), 65536);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
